lfgm_ram_arb: RTL and testbench
===============================

# lfgm_ram_arb

Arbiter and bank scheduler for the double-buffered life-game cell RAM. It sits between the RAM and three requesters: the generation engine, the display scan reader and the random-pattern regenerator. Each cycle it grants at most one requester and maps that requester's address onto the correct bank using the current RAM face. It registers the command into the single RAM port and returns tagged read data with fixed latency.

## Interface
Clock is `clk`; reset is `rst_n`, asynchronous and active-low.

Parameters:
- AW, 6, cell-row address width (row addresses 0..63)
- DW, 80, cell-row data width
- DSP_MAX_WAIT, 4, cycles the display may be refused before it is promoted (age feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ram_face  in  1  current face: engine and display read bank ram_face; engine and regenerator write bank ~ram_face
- eng_req  in  1  engine request, level, held until eng_gnt
- eng_we  in  1  engine write (1) / read (0)
- eng_adr  in  AW  engine row address
- eng_wdata  in  DW  engine write data
- eng_gnt  out  1  engine grant, one-cycle pulse
- eng_rvld  out  1  engine read data valid
- dsp_req  in  1  display read request, level
- dsp_adr  in  AW  display row address
- dsp_gnt  out  1  display grant
- dsp_rvld  out  1  display read data valid
- rg_req  in  1  regenerator write request, level
- rg_adr  in  AW  regenerator row address
- rg_wdata  in  DW  regenerator write data
- rg_gnt  out  1  regenerator grant
- rdata  out  DW  read data shared by eng_rvld and dsp_rvld
- ram_adr  out  AW+1  RAM address; MSB is the bank
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, one cycle after ram_adr
- busy  out  1  a command is in the pipeline

## Operation
- Grant logic is combinational from the request lines and the age state. Exactly zero or one gnt is high per cycle.
- Base priority is engine, then display, then regenerator.
- A requester that sees its gnt high at a rising edge has its command accepted. It must drop or change its request the following cycle.
- On grant, the register stage captures:
  - the bank: ram_face for a read, ~ram_face for a write
  - the address, we and wdata
  - a 2-bit tag: none, eng, or dsp
- The bank is frozen at grant. A ram_face toggle after grant does not affect a command in flight.
- The regenerator's requests are always writes.
- The tag pipeline is two stages deep. At stage 2, rdata is ram_rdata, registered, and the tagged rvld is pulsed. Writes produce no rvld.
- Age counter `dsp_wait`, width clog2(DSP_MAX_WAIT+1):
  - increments each cycle dsp_req is high and dsp_gnt is low
  - saturates at DSP_MAX_WAIT
  - clears on dsp_gnt or when dsp_req is low
- When dsp_wait == DSP_MAX_WAIT, the display outranks the engine.
- busy = OR of the command-valid bit and both tag stages.

## Timing
- Reset values:
  - every gnt = 0 (grants are combinational, but all forced 0 while rst_n is low)
  - rvld = 0, rdata = 0
  - ram_adr = 0, ram_we = 0, ram_wdata = 0
  - dsp_wait = 0, tags = none, busy = 0
- Grant at edge N: ram_adr, ram_we and ram_wdata are valid in cycle N+1. ram_we is high for exactly one cycle.
- A read granted at N has its rvld and rdata in cycle N+2. rdata holds its value until the next rvld.
- Throughput is one command per cycle. Back-to-back grants to different requesters are allowed.
- Simultaneous eng_req, dsp_req and rg_req: the engine wins. The regenerator is served only in a cycle with no engine or display request.
- Reset mid-operation clears the pipeline. Reads in flight are lost and no rvld is emitted for them.
- ram_face is sampled only at grant.

## Configuration
- LFGM_ARB_AGE_EN defined: the dsp_wait counter and display promotion are compiled in, so the display is refused for at most DSP_MAX_WAIT consecutive cycles.
- LFGM_ARB_AGE_EN undefined: no counter, strict fixed priority. The display can be starved indefinitely by a continuous eng_req.

## Test plan
- Reset, then eng_req read at address 5 with ram_face = 0 → eng_gnt in the same cycle, ram_adr = 7'h05 and ram_we = 0 the next cycle, eng_rvld with rdata = RAM[0][5] two cycles after grant.
- Engine write at address 61 with ram_face = 1 → ram_adr = 7'h3D (bank 0), ram_we high for 1 cycle, ram_wdata equal to eng_wdata, no rvld.
- eng_req, dsp_req and rg_req all high in one cycle → eng_gnt only. With the engine dropped, dsp_gnt the next cycle, then rg_gnt. One command per cycle, in order.
- With LFGM_ARB_AGE_EN and DSP_MAX_WAIT = 4, hold eng_req continuously plus dsp_req → dsp_gnt on the 5th cycle. Without the macro, dsp_gnt never occurs while eng_req is held.
- Grant a display read at ram_face = 0, toggle ram_face the next cycle → the read still targets bank 0 and dsp_rvld arrives at N+2.
- Assert rst_n low one cycle after a read grant → no rvld ever for that read, and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/lfgm_ram_arb_if.sv
// Requester handshakes, single RAM command port and tagged read return of the cell-RAM arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface lfgm_ram_arb_if #(
   parameter int AW = 6,
   parameter int DW = 80
);
   logic          ram_face;
   logic          eng_req;
   logic          eng_we;
   logic [AW-1:0] eng_adr;
   logic [DW-1:0] eng_wdata;
   logic          eng_gnt;
   logic          eng_rvld;
   logic          dsp_req;
   logic [AW-1:0] dsp_adr;
   logic          dsp_gnt;
   logic          dsp_rvld;
   logic          rg_req;
   logic [AW-1:0] rg_adr;
   logic [DW-1:0] rg_wdata;
   logic          rg_gnt;
   logic [DW-1:0] rdata;
   logic [AW:0]   ram_adr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          busy;

   modport slave (
      input  ram_face,
      input  eng_req, eng_we, eng_adr, eng_wdata,
      output eng_gnt, eng_rvld,
      input  dsp_req, dsp_adr,
      output dsp_gnt, dsp_rvld,
      input  rg_req, rg_adr, rg_wdata,
      output rg_gnt,
      output rdata,
      output ram_adr, ram_we, ram_wdata,
      input  ram_rdata,
      output busy
   );

   modport master (
      output ram_face,
      output eng_req, eng_we, eng_adr, eng_wdata,
      input  eng_gnt, eng_rvld,
      output dsp_req, dsp_adr,
      input  dsp_gnt, dsp_rvld,
      output rg_req, rg_adr, rg_wdata,
      input  rg_gnt,
      input  rdata,
      input  ram_adr, ram_we, ram_wdata,
      output ram_rdata,
      input  busy
   );
endinterface

// File: rtl/lfgm_ram_arb.sv
// Cell-RAM arbiter: grants engine > display > regenerator combinationally, command on RAM port next cycle,
// read data + rvld two cycles after grant. LFGM_ARB_AGE_EN adds display aging (promotion after DSP_MAX_WAIT refusals).
module lfgm_ram_arb #(
   parameter int AW           = 6,
   parameter int DW           = 80,
   parameter int DSP_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   lfgm_ram_arb_if.slave     bus
);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_ENG  = 2'd1,
      TAG_DSP  = 2'd2
   } tag_e;

   logic          eng_gnt;
   logic          dsp_gnt;
   logic          rg_gnt;
   logic          dsp_first;

   logic          cmd_vld_q,   cmd_vld_d;
   logic [AW:0]   ram_adr_q,   ram_adr_d;
   logic          ram_we_q,    ram_we_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   tag_e          tag1_q,      tag1_d;
   tag_e          tag2_q,      tag2_d;
   logic [DW-1:0] rdata_q,     rdata_d;

`ifdef LFGM_ARB_AGE_EN
   localparam int WW = $clog2(DSP_MAX_WAIT + 1);

   logic [WW-1:0] dsp_wait_q, dsp_wait_d;

   always_comb begin
      dsp_wait_d = '0;
      if (bus.dsp_req && !dsp_gnt) begin
         dsp_wait_d = (dsp_wait_q == WW'(DSP_MAX_WAIT)) ? dsp_wait_q : dsp_wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsp_wait_q <= '0;
      end else begin
         dsp_wait_q <= dsp_wait_d;
      end
   end

   assign dsp_first = (dsp_wait_q == WW'(DSP_MAX_WAIT));
`else
   assign dsp_first = 1'b0;
`endif

   // Grants are forced low during reset so nothing is accepted while the pipeline is cleared.
   always_comb begin
      eng_gnt = 1'b0;
      dsp_gnt = 1'b0;
      rg_gnt  = 1'b0;
      if (rst_n) begin
         if (bus.dsp_req && dsp_first) begin
            dsp_gnt = 1'b1;
         end else if (bus.eng_req) begin
            eng_gnt = 1'b1;
         end else if (bus.dsp_req) begin
            dsp_gnt = 1'b1;
         end else if (bus.rg_req) begin
            rg_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      cmd_vld_d   = eng_gnt | dsp_gnt | rg_gnt;
      ram_adr_d   = ram_adr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      tag1_d      = TAG_NONE;
      if (eng_gnt) begin
         ram_we_d    = bus.eng_we;
         ram_adr_d   = {bus.eng_we ? ~bus.ram_face : bus.ram_face, bus.eng_adr};
         ram_wdata_d = bus.eng_wdata;
         tag1_d      = bus.eng_we ? TAG_NONE : TAG_ENG;
      end else if (dsp_gnt) begin
         ram_adr_d = {bus.ram_face, bus.dsp_adr};
         tag1_d    = TAG_DSP;
      end else if (rg_gnt) begin
         ram_we_d    = 1'b1;
         ram_adr_d   = {~bus.ram_face, bus.rg_adr};
         ram_wdata_d = bus.rg_wdata;
      end
      tag2_d  = tag1_q;
      rdata_d = (tag2_q != TAG_NONE) ? bus.ram_rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_vld_q   <= 1'b0;
         ram_adr_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         tag1_q      <= TAG_NONE;
         tag2_q      <= TAG_NONE;
         rdata_q     <= '0;
      end else begin
         cmd_vld_q   <= cmd_vld_d;
         ram_adr_q   <= ram_adr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.eng_gnt   = eng_gnt;
   assign bus.dsp_gnt   = dsp_gnt;
   assign bus.rg_gnt    = rg_gnt;
   assign bus.ram_adr   = ram_adr_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.eng_rvld  = (tag2_q == TAG_ENG);
   assign bus.dsp_rvld  = (tag2_q == TAG_DSP);
   // The RAM output register is the data stage; rdata_q holds the last returned row between reads.
   assign bus.rdata     = (tag2_q != TAG_NONE) ? bus.ram_rdata : rdata_q;
   assign bus.busy      = cmd_vld_q | (tag1_q != TAG_NONE) | (tag2_q != TAG_NONE);

endmodule

// File: tb/tb_lfgm_ram_arb.sv
// Directed bench for lfgm_ram_arb with a synchronous RAM model whose rows are a function of the address.
module tb_lfgm_ram_arb;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   lfgm_ram_arb_if #(.AW(6), .DW(80)) bus ();

   lfgm_ram_arb #(.AW(6), .DW(80), .DSP_MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [79:0] pat(input logic [6:0] a);
      return {16'hC0DE, 8'h00, {8{1'b0, a}}};
   endfunction

   always @(posedge clk) bus.ram_rdata <= pat(bus.ram_adr);

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".gnt"},   {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 0);
      check({tag, ".rvld"},  {bus.eng_rvld, bus.dsp_rvld}, 0);
      check({tag, ".rdata"}, bus.rdata, 0);
      check({tag, ".adr"},   bus.ram_adr, 0);
      check({tag, ".we"},    bus.ram_we, 0);
      check({tag, ".wdata"}, bus.ram_wdata, 0);
      check({tag, ".busy"},  bus.busy, 0);
   endtask

   initial begin
      logic exp_dsp;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.ram_face  = 1'b0;
      bus.eng_req   = 1'b1;
      bus.eng_we    = 1'b0;
      bus.eng_adr   = 6'd0;
      bus.eng_wdata = '0;
      bus.dsp_req   = 1'b0;
      bus.dsp_adr   = 6'd0;
      bus.rg_req    = 1'b0;
      bus.rg_adr    = 6'd0;
      bus.rg_wdata  = '0;

      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n       = 1'b1;
      bus.eng_req = 1'b0;

      // engine read, address 5, face 0
      bus.eng_req = 1'b1;
      bus.eng_we  = 1'b0;
      bus.eng_adr = 6'd5;
      mid();
      check("rd5.gnt", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b100);
      tick();
      bus.eng_req = 1'b0;
      check("rd5.adr", bus.ram_adr, 7'h05);
      check("rd5.we", bus.ram_we, 0);
      check("rd5.busy", bus.busy, 1);
      check("rd5.early_rvld", bus.eng_rvld, 0);
      tick();
      check("rd5.rvld", {bus.eng_rvld, bus.dsp_rvld}, 2'b10);
      check("rd5.rdata", bus.rdata, pat(7'h05));
      tick();
      check("rd5.rvld_off", bus.eng_rvld, 0);
      check("rd5.rdata_hold", bus.rdata, pat(7'h05));
      check("rd5.idle", bus.busy, 0);

      // engine write, address 61, face 1 -> bank 0
      bus.ram_face  = 1'b1;
      bus.eng_req   = 1'b1;
      bus.eng_we    = 1'b1;
      bus.eng_adr   = 6'd61;
      bus.eng_wdata = 80'hDEAD_BEEF_0123_4567_89AB;
      mid();
      check("wr61.gnt", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b100);
      tick();
      bus.eng_req = 1'b0;
      bus.eng_we  = 1'b0;
      check("wr61.adr", bus.ram_adr, 7'h3D);
      check("wr61.we", bus.ram_we, 1);
      check("wr61.wdata", bus.ram_wdata, 80'hDEAD_BEEF_0123_4567_89AB);
      tick();
      check("wr61.we_off", bus.ram_we, 0);
      check("wr61.no_rvld1", {bus.eng_rvld, bus.dsp_rvld}, 0);
      tick();
      check("wr61.no_rvld2", {bus.eng_rvld, bus.dsp_rvld}, 0);

      // all three requesting at face 0
      bus.ram_face = 1'b0;
      bus.eng_req  = 1'b1;
      bus.eng_adr  = 6'd1;
      bus.dsp_req  = 1'b1;
      bus.dsp_adr  = 6'd2;
      bus.rg_req   = 1'b1;
      bus.rg_adr   = 6'd3;
      bus.rg_wdata = 80'h1111_2222_3333_4444_5555;
      mid();
      check("tri.gnt_eng", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b100);
      tick();
      bus.eng_req = 1'b0;
      check("tri.adr_eng", bus.ram_adr, 7'h01);
      mid();
      check("tri.gnt_dsp", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b010);
      tick();
      bus.dsp_req = 1'b0;
      check("tri.adr_dsp", {bus.ram_we, bus.ram_adr}, {1'b0, 7'h02});
      check("tri.eng_rvld", {bus.eng_rvld, bus.dsp_rvld}, 2'b10);
      check("tri.eng_rdata", bus.rdata, pat(7'h01));
      mid();
      check("tri.gnt_rg", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b001);
      tick();
      bus.rg_req = 1'b0;
      check("tri.adr_rg", {bus.ram_we, bus.ram_adr}, {1'b1, 7'h43});
      check("tri.wdata_rg", bus.ram_wdata, 80'h1111_2222_3333_4444_5555);
      check("tri.dsp_rvld", {bus.eng_rvld, bus.dsp_rvld}, 2'b01);
      check("tri.dsp_rdata", bus.rdata, pat(7'h02));
      tick();
      check("tri.drain", {bus.ram_we, bus.eng_rvld, bus.dsp_rvld}, 0);
      tick();

      // engine held with display pending: aging decides the 5th cycle
      bus.eng_req = 1'b1;
      bus.eng_adr = 6'd4;
      bus.dsp_req = 1'b1;
      bus.dsp_adr = 6'd6;
      for (int c = 1; c <= 8; c++) begin
`ifdef LFGM_ARB_AGE_EN
         exp_dsp = (c == 5);
`else
         exp_dsp = 1'b0;
`endif
         mid();
         check($sformatf("age.c%0d", c), {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt},
               {~exp_dsp, exp_dsp, 1'b0});
         tick();
      end
      bus.eng_req = 1'b0;
      bus.dsp_req = 1'b0;
      tick();
      tick();

      // display read at face 0, face flips right after the grant
      bus.ram_face = 1'b0;
      bus.dsp_req  = 1'b1;
      bus.dsp_adr  = 6'd9;
      mid();
      check("face.gnt", {bus.eng_gnt, bus.dsp_gnt, bus.rg_gnt}, 3'b010);
      tick();
      bus.dsp_req  = 1'b0;
      bus.ram_face = 1'b1;
      check("face.adr", bus.ram_adr, 7'h09);
      tick();
      check("face.rvld", {bus.eng_rvld, bus.dsp_rvld}, 2'b01);
      check("face.rdata", bus.rdata, pat(7'h09));
      bus.ram_face = 1'b0;
      tick();

      // reset one cycle after a read grant
      bus.eng_req = 1'b1;
      bus.eng_we  = 1'b0;
      bus.eng_adr = 6'd12;
      mid();
      check("rst.gnt", bus.eng_gnt, 1);
      tick();
      check("rst.adr_pre", bus.ram_adr, 7'h0C);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst.mid");
      bus.eng_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("rst.no_rvld%0d", c), {bus.eng_rvld, bus.dsp_rvld, bus.busy}, 0);
      end
      check("rst.rdata", bus.rdata, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
